usb_crc_encoder: RTL and testbench

- Transmit-side counterpart of the packet decoder: accepts a parallel USB-style packet (PID plus fields), serializes it MSB-first, and appends a serially computed CRC5 (token) or CRC16 (data).
- Handshake packets carry only the PID byte.
- Output stream is bit-for-bit what the decoder's shift-left collector, CRC check and done input expect.

---
 rtl/usb_crc_encoder_pkg.sv | 22 ++
 rtl/usb_crc_encoder_crc.sv | 40 ++++
 rtl/usb_crc_encoder.sv | 153 +++++++++++++++
 tb/tb_usb_crc_encoder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_crc_encoder_pkg.sv
// rtl/usb_crc_encoder_pkg.sv - shared types and constants for the USB packet encoder
// Holds the encoder state type, PID classification constants, CRC polynomials,
// presets and receiver residues, and token field widths.
package usb_pkg;

  typedef enum logic [1:0] {IDLE, PID, BODY, CRC} encState_t;

  localparam logic [3:0] PID_DATA     = 4'b1100;
  localparam logic [2:0] TOKEN_PREFIX = 3'b100;

  // Polynomials are written without the implicit x^WIDTH term.
  localparam logic [4:0]  CRC5_POLY     = 5'b00101;
  localparam logic [4:0]  CRC5_INIT     = 5'b11111;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  localparam int ADDR_W = 7;
  localparam int ENDP_W = 4;

endpackage

// File: rtl/usb_crc_encoder_crc.sv
// rtl/usb_crc_encoder_crc.sv - serial LFSR CRC generator
// Ports: clk, rst (async, active high), en (absorb bitIn this cycle),
// clr (return to INIT), bitIn (serial data), crc (parallel value).
// crc already includes the bit being absorbed when en is high, so a caller can
// capture the final CRC on the same edge that consumes the last message bit.
module crc_serial_gen #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             bitIn,
  output logic [WIDTH-1:0] crc
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nxt;
  logic             fb;

  always_comb begin
    fb  = bitIn ^ q[WIDTH-1];
    nxt = {q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= INIT;
    end else if (clr) begin
      q <= INIT;
    end else if (en) begin
      q <= nxt;
    end
  end

  assign crc = en ? nxt : q;

endmodule

// File: rtl/usb_crc_encoder.sv
// rtl/usb_crc_encoder.sv - parallel USB packet to serial bit stream with CRC5/CRC16
// Ports: clk, rst (async, active high); pktInAvail/readyIn load handshake with
// pid, addr, endp, data; bitOut/bitOutAvail/readyOut serial output handshake;
// done marks the transfer of the last bit of a packet.
// Optional macro USB_ENC_ERR_INJECT_EN adds input errInject, which corrupts the
// last CRC bit of token/data packets loaded with it high.
module usb_crc_encoder
  import usb_pkg::*;
#(
  parameter int DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pktInAvail,
  output logic                 readyIn,
  input  logic [3:0]           pid,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [ENDP_W-1:0]    endp,
  input  logic [DATA_BITS-1:0] data,
`ifdef USB_ENC_ERR_INJECT_EN
  input  logic                 errInject,
`endif
  output logic                 bitOut,
  output logic                 bitOutAvail,
  input  logic                 readyOut,
  output logic                 done
);

  // Body area must hold either a token's addr+endp or the data payload.
  localparam int TOK_W  = ADDR_W + ENDP_W;
  localparam int BODY_W = (DATA_BITS > TOK_W) ? DATA_BITS : TOK_W;
  localparam int SW     = 8 + BODY_W;

  encState_t   state;
  logic [6:0]  cnt;
  logic [6:0]  last_cnt;
  logic [SW-1:0] sreg;
  logic [SW-1:0] sreg_load;
  logic [15:0] crc_sr;
  logic [15:0] crc_load;
  logic        is_tok;
  logic        is_data;
  logic        inj;
  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic        xfer;
  logic        last;
  logic        load;
  logic        body_xfer;

  assign readyIn     = (state == IDLE);
  assign bitOutAvail = (state != IDLE);
  assign xfer        = bitOutAvail && readyOut;
  assign load        = pktInAvail && readyIn;
  assign body_xfer   = xfer && (state == BODY);
  assign bitOut      = (state == CRC) ? crc_sr[15] : sreg[SW-1];
  assign last        = (cnt == last_cnt);
  assign done        = xfer && last &&
                       ((state == CRC) || ((state == PID) && !is_tok && !is_data));

  // Packet is left-justified so the PID MSB sits at the shift-out end.
  always_comb begin
    sreg_load = SW'({pid, ~pid}) << BODY_W;
    if (pid[3:1] == TOKEN_PREFIX) begin
      sreg_load = SW'({pid, ~pid, addr, endp}) << (BODY_W - TOK_W);
    end else if (pid == PID_DATA) begin
      sreg_load = SW'({pid, ~pid, data}) << (BODY_W - DATA_BITS);
    end
  end

  // CRC5 is placed in the top bits so both CRCs leave from crc_sr[15].
  always_comb begin
    crc_load = is_tok ? {~crc5, 11'b0} : ~crc16;
    if (inj) begin
      crc_load = crc_load ^ (is_tok ? 16'h0800 : 16'h0001);
    end
  end

  always_comb begin
    last_cnt = 7'd0;
    case (state)
      PID:     last_cnt = 7'd7;
      BODY:    last_cnt = is_tok ? 7'(TOK_W - 1) : 7'(DATA_BITS - 1);
      CRC:     last_cnt = is_tok ? 7'd4 : 7'd15;
      default: last_cnt = 7'd0;
    endcase
  end

`ifndef USB_ENC_ERR_INJECT_EN
  assign inj = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sreg    <= '0;
      crc_sr  <= '0;
      is_tok  <= 1'b0;
      is_data <= 1'b0;
`ifdef USB_ENC_ERR_INJECT_EN
      inj     <= 1'b0;
`endif
    end else if (load) begin
      state   <= PID;
      cnt     <= '0;
      sreg    <= sreg_load;
      is_tok  <= (pid[3:1] == TOKEN_PREFIX);
      is_data <= (pid == PID_DATA);
`ifdef USB_ENC_ERR_INJECT_EN
      inj     <= errInject;
`endif
    end else if (xfer) begin
      if (state == CRC) begin
        crc_sr <= {crc_sr[14:0], 1'b0};
      end else begin
        sreg <= {sreg[SW-2:0], 1'b0};
      end
      if (last) begin
        cnt <= '0;
        case (state)
          PID:     state <= (is_tok || is_data) ? BODY : IDLE;
          BODY: begin
            state  <= CRC;
            crc_sr <= crc_load;
          end
          default: state <= IDLE;
        endcase
      end else begin
        cnt <= cnt + 7'd1;
      end
    end
  end

  crc_serial_gen #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .clk   (clk),
    .rst   (rst),
    .en    (body_xfer && is_tok),
    .clr   (load),
    .bitIn (sreg[SW-1]),
    .crc   (crc5)
  );

  crc_serial_gen #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clk   (clk),
    .rst   (rst),
    .en    (body_xfer && is_data),
    .clr   (load),
    .bitIn (sreg[SW-1]),
    .crc   (crc16)
  );

endmodule

// File: tb/tb_usb_crc_encoder.sv
// tb/tb_usb_crc_encoder.sv - scoreboard bench for usb_crc_encoder
module tb_usb_crc_encoder;
  import usb_pkg::*;

  localparam int DB = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pktInAvail = 1'b0;
  logic          readyIn;
  logic [3:0]    pid = '0;
  logic [6:0]    addr = '0;
  logic [3:0]    endp = '0;
  logic [DB-1:0] data = '0;
`ifdef USB_ENC_ERR_INJECT_EN
  logic          errInject = 1'b0;
`endif
  logic          bitOut;
  logic          bitOutAvail;
  logic          readyOut = 1'b1;
  logic          done;

  typedef struct packed {logic b; logic d;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   obs[$];
  int   bits_seen = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rand_bp = 1'b0;

  usb_crc_encoder #(.DATA_BITS(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .pktInAvail  (pktInAvail),
    .readyIn     (readyIn),
    .pid         (pid),
    .addr        (addr),
    .endp        (endp),
    .data        (data),
`ifdef USB_ENC_ERR_INJECT_EN
    .errInject   (errInject),
`endif
    .bitOut      (bitOut),
    .bitOutAvail (bitOutAvail),
    .readyOut    (readyOut),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Polynomial long division with all-ones preset; returns the receiver-side register value.
  function automatic logic [15:0] crc_rem(input bit msg[$], input int w);
    bit          a[$];
    logic [16:0] gen;
    logic [15:0] r;
    r   = '0;
    gen = (w == 5) ? 17'h00025 : 17'h18005;
    a   = msg;
    for (int i = 0; i < w; i++) a.push_back(1'b0);
    for (int i = 0; i < w; i++) a[i] = ~a[i];
    for (int i = 0; i < msg.size(); i++)
      if (a[i])
        for (int j = 0; j <= w; j++) a[i+j] = a[i+j] ^ gen[w-j];
    for (int j = 0; j < w; j++) r = {r[14:0], a[msg.size()+j]};
    return r;
  endfunction

  function automatic logic [15:0] obs_residue(input int w);
    bit s[$];
    for (int i = 8; i < obs.size(); i++) s.push_back(obs[i]);
    return crc_rem(s, w);
  endfunction

  task automatic push_pkt(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                          input logic [DB-1:0] d, input bit inj);
    bit          all[$];
    bit          body[$];
    logic [7:0]  pb;
    logic [15:0] c;
    bit          tok;
    bit          dat;
    int          w;
    pb  = {p, ~p};
    tok = (p[3:1] == 3'b100);
    dat = (p == 4'b1100);
    for (int i = 7; i >= 0; i--) all.push_back(pb[i]);
    if (tok) begin
      for (int i = 6; i >= 0; i--) body.push_back(a[i]);
      for (int i = 3; i >= 0; i--) body.push_back(e[i]);
    end else if (dat) begin
      for (int i = DB-1; i >= 0; i--) body.push_back(d[i]);
    end
    if (tok || dat) begin
      w = tok ? 5 : 16;
      c = ~crc_rem(body, w);
      foreach (body[i]) all.push_back(body[i]);
      for (int i = w-1; i >= 0; i--) all.push_back(c[i]);
      if (inj) all[all.size()-1] = ~all[all.size()-1];
    end
    for (int i = 0; i < all.size(); i++) exp_q.push_back('{b: all[i], d: (i == all.size()-1)});
  endtask

  task automatic send(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                      input logic [DB-1:0] d, input bit inj);
    int n = 0;
    while (!readyIn && n < 400) begin
      @(posedge clk); #1;
      readyOut = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      n++;
    end
    if (!readyIn) begin
      n_checks++; n_fail++;
      $display("FAIL load_wait: readyIn still %0b after %0d cycles, expected 1", readyIn, n);
    end
    pid = p; addr = a; endp = e; data = d; pktInAvail = 1'b1;
`ifdef USB_ENC_ERR_INJECT_EN
    errInject = inj;
`endif
    push_pkt(p, a, e, d, inj);
    @(posedge clk); #1;
    pktInAvail = 1'b0;
    if (rand_bp) readyOut = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !readyIn) && n < 1000) begin
      @(posedge clk); #1;
      readyOut = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      n++;
    end
    readyOut = 1'b1;
    if (exp_q.size() != 0 || !readyIn) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d bits still pending, readyIn %0b", exp_q.size(), readyIn);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bitOutAvail && readyOut) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_bit: got bitOut %0b, expected no transfer", bitOut);
        end else begin
          mon_e = exp_q.pop_front();
          check("bit", bitOut, mon_e.b);
          check("done", done, mon_e.d);
        end
        obs.push_back(bitOut);
        bits_seen++;
      end else begin
        check("done_no_xfer", done, 0);
        if (bitOutAvail && exp_q.size() > 0) check("stall_bit", bitOut, exp_q[0].b);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int stall;
    repeat (3) @(posedge clk);
    #1;
    check("rst_readyIn", readyIn, 1);
    check("rst_avail", bitOutAvail, 0);
    check("rst_bitOut", bitOut, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Handshake timing: first bit at T+1, done on 8th, readyIn at T+9
    obs.delete();
    send(4'b0010, 7'h0, 4'h0, '0, 1'b0);
    check("hs_first_avail", bitOutAvail, 1);
    repeat (7) begin @(posedge clk); #1; end
    check("hs_done_8th", done, 1);
    check("hs_busy_on_done", readyIn, 0);
    @(posedge clk); #1;
    check("hs_ready_again", readyIn, 1);
    check("hs_len", obs.size(), 8);

    // Token
    obs.delete();
    send(4'b1001, 7'h15, 4'hA, '0, 1'b0);
    wait_done();
    check("tok_len", obs.size(), 24);
    check("tok_residue", obs_residue(5), {11'b0, CRC5_RESIDUE});

    // Data
    obs.delete();
    send(4'b1100, 7'h0, 4'h0, 64'h0123456789ABCDEF, 1'b0);
    wait_done();
    check("data_len", obs.size(), 88);
    check("data_residue", obs_residue(16), CRC16_RESIDUE);

    // Backpressure: 3-cycle stall after bit 10
    obs.delete();
    bits_seen = 0;
    stall = 0;
    n = 0;
    send(4'b1001, 7'h15, 4'hA, '0, 1'b0);
    while (!readyIn && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bits_seen >= 10 && stall < 3) begin
        readyOut = 1'b0;
        stall++;
      end else begin
        readyOut = 1'b1;
      end
    end
    check("bp_cycles", n, 27);
    check("bp_len", obs.size(), 24);
    check("bp_residue", obs_residue(5), {11'b0, CRC5_RESIDUE});

    // Reset mid-data after bit 40
    bits_seen = 0;
    n = 0;
    send(4'b1100, 7'h0, 4'h0, {$urandom, $urandom}, 1'b0);
    while (bits_seen < 40 && n < 200) begin @(posedge clk); #1; n++; end
    check("mid_bits", bits_seen, 40);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_avail", bitOutAvail, 0);
    check("mid_rst_readyIn", readyIn, 1);
    check("mid_rst_bitOut", bitOut, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    obs.delete();
    send(4'b1010, 7'h0, 4'h0, '0, 1'b0);
    wait_done();
    check("post_rst_hs_len", obs.size(), 8);

`ifdef USB_ENC_ERR_INJECT_EN
    obs.delete();
    send(4'b1001, 7'h15, 4'hA, '0, 1'b1);
    wait_done();
    check("inj_residue_bad", (obs_residue(5) != {11'b0, CRC5_RESIDUE}), 1);
`endif

    // Randomized back-to-back traffic with backpressure
    rand_bp = 1'b1;
    repeat (40) begin
      logic [3:0] p;
      bit inj;
      case ($urandom_range(0, 3))
        0:       p = {3'b100, 1'($urandom_range(0, 1))};
        1:       p = 4'b1100;
        default: p = 4'($urandom_range(0, 15));
      endcase
      inj = 1'b0;
`ifdef USB_ENC_ERR_INJECT_EN
      inj = 1'($urandom_range(0, 1));
`endif
      send(p, 7'($urandom), 4'($urandom), {$urandom, $urandom}, inj);
    end
    wait_done();
    rand_bp = 1'b0;
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
